// File: rtl/regfile_read_arbiter_if.sv
// rtl/regfile_read_arbiter_if.sv - requester/register-mux/response bundle for regfile_read_arbiter
interface regfile_read_arbiter_if #(
  parameter int N = 64
);
  logic [3:0]   req_valid;
  logic [19:0]  req_addr;
  logic [3:0]   req_ready;
  logic [4:0]   sel;
  logic [N-1:0] rd_data;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic [N-1:0] resp_data;
  logic         resp_ready;

  modport slave (
    input  req_valid, req_addr, rd_data, resp_ready,
    output req_ready, sel, resp_valid, resp_id, resp_data
  );

  modport master (
    output req_valid, req_addr, rd_data, resp_ready,
    input  req_ready, sel, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - 4-way round-robin register read arbiter with 1-entry response register
// Optional feature: define REGFILE_XZR_EN to make register 31 read as zero.
module regfile_read_arbiter #(
  parameter int N = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_read_arbiter_if.slave  bus
);

  logic [1:0]   rr_ptr;
  logic [4:0]   sel_q;
  logic         resp_valid_q;
  logic [1:0]   resp_id_q;
  logic [N-1:0] resp_data_q;

  logic         free;
  logic         grant;
  logic [1:0]   gnt_idx;
  logic [1:0]   cand;
  logic [4:0]   addr_of [4];
  logic [4:0]   gnt_addr;
  logic [N-1:0] cap_data;

  // The response slot is free if empty or being drained this very cycle.
  assign free = !resp_valid_q || bus.resp_ready;

  always_comb begin
    grant   = 1'b0;
    gnt_idx = rr_ptr;
    cand    = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      addr_of[k] = bus.req_addr[5*k +: 5];
    end
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!grant && bus.req_valid[cand]) begin
        grant   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!rst_n || !free) begin
      grant = 1'b0;
    end
    gnt_addr = addr_of[gnt_idx];
`ifdef REGFILE_XZR_EN
    cap_data = (gnt_addr == 5'd31) ? '0 : bus.rd_data;
`else
    cap_data = bus.rd_data;
`endif
  end

  assign bus.req_ready  = grant ? (4'b0001 << gnt_idx) : 4'b0000;
  assign bus.sel        = grant ? gnt_addr : sel_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= 2'd0;
      sel_q        <= 5'd0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 2'd0;
      resp_data_q  <= '0;
    end else if (grant) begin
      rr_ptr       <= gnt_idx + 2'd1;
      sel_q        <= gnt_addr;
      resp_valid_q <= 1'b1;
      resp_id_q    <= gnt_idx;
      resp_data_q  <= cap_data;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - self-checking bench for regfile_read_arbiter
module tb_regfile_read_arbiter;

  localparam int N = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] regs [32];

  int errors = 0;
  int checks = 0;

  regfile_read_arbiter_if #(.N(N)) bus ();

  regfile_read_arbiter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // External 32:1 register mux driven by the DUT's select.
  assign bus.rd_data = regs[bus.sel];

  // Model state: what the response register, pointer and held select must contain.
  logic         m_valid = 1'b0;
  int           m_id    = 0;
  logic [N-1:0] m_data  = '0;
  int           m_ptr   = 0;
  int           m_sel   = 0;

  function automatic int addr_of(input logic [19:0] a, input int i);
    return int'((a >> (5 * i)) & 20'h1f);
  endfunction

  function automatic int pick(input logic [3:0] v, input int ptr, input logic permitted);
    if (!permitted) return -1;
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] reg_value(input int a);
`ifdef REGFILE_XZR_EN
    if (a == 31) return '0;
`endif
    return regs[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_id    = 0;
      m_data  = '0;
      m_ptr   = 0;
      m_sel   = 0;
    end else begin
      g = pick(bus.req_valid, m_ptr, !m_valid || bus.resp_ready);
      if (g >= 0) begin
        m_sel   = addr_of(bus.req_addr, g);
        m_valid = 1'b1;
        m_id    = g;
        m_data  = reg_value(m_sel);
        m_ptr   = (g + 1) % 4;
      end else if (bus.resp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [3:0] e_ready;
    int e_sel;
    g = pick(bus.req_valid, m_ptr, rst_n && (!m_valid || bus.resp_ready));
    e_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    e_sel   = (g >= 0) ? addr_of(bus.req_addr, g) : m_sel;
    check("model req_ready", 64'(bus.req_ready), 64'(e_ready));
    check("model sel", 64'(bus.sel), 64'(e_sel));
    check("model resp_valid", 64'(bus.resp_valid), 64'(m_valid));
    check("model resp_id", 64'(bus.resp_id), 64'(m_id));
    check("model resp_data", 64'(bus.resp_data), 64'(m_data));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [19:0] addr;
    logic        ready;
  } vec_t;

  vec_t table_v [8];

  initial begin
    bus.req_valid  = 4'b0000;
    bus.req_addr   = 20'd0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i) * 64'h11;
    regs[7]  = 64'hA5;
    regs[31] = 64'hFFFF;

    table_v[0] = '{4'b1111, {5'd31, 5'd9, 5'd8, 5'd7}, 1'b1};
    table_v[1] = '{4'b1010, {5'd12, 5'd13, 5'd14, 5'd15}, 1'b0};
    table_v[2] = '{4'b1010, {5'd12, 5'd13, 5'd14, 5'd15}, 1'b0};
    table_v[3] = '{4'b0101, {5'd20, 5'd21, 5'd22, 5'd23}, 1'b1};
    table_v[4] = '{4'b0000, {5'd20, 5'd21, 5'd22, 5'd23}, 1'b1};
    table_v[5] = '{4'b0000, {5'd20, 5'd21, 5'd22, 5'd23}, 1'b1};
    table_v[6] = '{4'b1001, {5'd31, 5'd1, 5'd2, 5'd31}, 1'b1};
    table_v[7] = '{4'b1001, {5'd31, 5'd1, 5'd2, 5'd31}, 1'b1};

    // Reset holds every output low even with requests pending.
    #1;
    bus.req_valid = 4'b1111;
    #1;
    check("reset req_ready", 64'(bus.req_ready), 64'h0);
    check("reset sel", 64'(bus.sel), 64'h0);
    check("reset resp_valid", 64'(bus.resp_valid), 64'h0);
    bus.req_valid = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;

    // Single request, granted in the first cycle after reset release.
    bus.req_valid  = 4'b0010;
    bus.req_addr   = 20'(7) << 5;
    bus.resp_ready = 1'b1;
    #1;
    check("single req_ready", 64'(bus.req_ready), 64'h2);
    check("single sel", 64'(bus.sel), 64'd7);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    check("single resp_valid", 64'(bus.resp_valid), 64'h1);
    check("single resp_id", 64'(bus.resp_id), 64'h1);
    check("single resp_data", 64'(bus.resp_data), 64'hA5);
    check("single sel hold", 64'(bus.sel), 64'd7);
    tick();
    check("drain resp_valid", 64'(bus.resp_valid), 64'h0);

    // All four requesting after reset: 0,1,2,3,0 with no bubbles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid  = 4'b1111;
    bus.req_addr   = {5'd4, 5'd3, 5'd2, 5'd1};
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr req_ready", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      check("rr sel", 64'(bus.sel), 64'((k % 4) + 1));
      if (k > 0) check("rr resp_valid", 64'(bus.resp_valid), 64'h1);
      tick();
    end

    // Backpressure: response from requester 0 (register 1) must hold.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp req_ready", 64'(bus.req_ready), 64'h0);
      check("bp resp_valid", 64'(bus.resp_valid), 64'h1);
      check("bp resp_id", 64'(bus.resp_id), 64'h0);
      check("bp resp_data", 64'(bus.resp_data), regs[1]);
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    check("bp release req_ready", 64'(bus.req_ready), 64'h4);
    check("bp release sel", 64'(bus.sel), 64'd3);
    tick();

    // Register 31 from requester 2.
    bus.req_addr  = 20'(31) << 10;
    #1;
    check("x31 req_ready", 64'(bus.req_ready), 64'h4);
    check("x31 sel", 64'(bus.sel), 64'd31);
    tick();
    bus.req_valid  = 4'b0000;
    bus.resp_ready = 1'b0;
    #1;
`ifdef REGFILE_XZR_EN
    check("x31 resp_data", 64'(bus.resp_data), 64'h0);
`else
    check("x31 resp_data", 64'(bus.resp_data), 64'hFFFF);
`endif

    // Asynchronous reset with a held response; pointer was 3 beforehand.
    rst_n = 1'b0;
    #1;
    check("async resp_valid", 64'(bus.resp_valid), 64'h0);
    check("async resp_data", 64'(bus.resp_data), 64'h0);
    tick();
    rst_n = 1'b1;
    bus.req_valid  = 4'b1111;
    bus.req_addr   = {5'd10, 5'd11, 5'd12, 5'd13};
    bus.resp_ready = 1'b1;
    #1;
    check("post reset req_ready", 64'(bus.req_ready), 64'h1);
    tick();

    // Requester 2 withdraws before its turn; requester 3 wins, pointer wraps to 0.
    bus.req_valid = 4'b0110;
    #1;
    check("skip first req_ready", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 4'b1000;
    #1;
    check("skip req_ready", 64'(bus.req_ready), 64'h8);
    tick();
    bus.req_valid = 4'b1111;
    #1;
    check("skip ptr wrap", 64'(bus.req_ready), 64'h1);
    tick();

    for (int i = 0; i < 8; i++) begin
      bus.req_valid  = table_v[i].valid;
      bus.req_addr   = table_v[i].addr;
      bus.resp_ready = table_v[i].ready;
      tick();
    end

    bus.req_valid  = 4'b0000;
    bus.resp_ready = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
